memory_stage: RTL and testbench
===============================

# memory_stage

Memory (MEM) stage of the SCHOLAR RISC-V core, between Execute and Writeback. Accepts one EXE->MEM micro-op at a time, performs the load or store over an OBI data-master port, and hands the MEM->WB payload plus load data to Writeback. Non-memory micro-ops pass through with one cycle of latency. At most one OBI transaction is outstanding at any time.

## Interface
- DATA_WIDTH, 32: data bus and GPR width.
- ADDR_WIDTH, 32: OBI address width.
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- exe_valid_i  in  1  EXE micro-op valid.
- exe2mem_i  in  exe2mem_t  payload: exe_out (result/address), op3 (store data), rd, csr_waddr, gpr_ctrl, csr_ctrl, mem_ctrl.
- mem_ready_o  out  1  stage can accept a micro-op this cycle.
- mem_valid_o  out  1  one-cycle pulse: mem2wb_o is valid for Writeback.
- mem2wb_o  out  mem2wb_t  payload to Writeback (same fields, registered).
- rdata_o  out  DATA_WIDTH  raw loaded word, valid the cycle after mem_valid_o.
- misaligned_o  out  1  pulse with mem_valid_o when the access was misaligned.
- req_o / gnt_i  out / in  1 / 1  OBI address-phase handshake.
- addr_o  out  ADDR_WIDTH  word-aligned address ({exe_out[ADDR_WIDTH-1:2], 2'b00}).
- we_o  out  1  1 = store.
- be_o  out  DATA_WIDTH/8  byte enables.
- wdata_o  out  DATA_WIDTH  lane-shifted store data.
- rvalid_i  in  1  OBI response valid.
- rdata_i  in  DATA_WIDTH  OBI response data.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: mem_ready_o = 1. On exe_valid_i, capture exe2mem_i into payload register.
  - mem_ctrl = MEM_IDLE -> DONE.
  - Load/store, aligned -> REQ.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> DONE with gpr_ctrl, csr_ctrl forced to GPR_IDLE/CSR_IDLE, rd = 0, misaligned flag set. No bus request issued.
- REQ: req_o = 1, address/we/be/wdata stable until gnt_i. On req_o && gnt_i -> RESP.
- RESP: req_o = 0. On rvalid_i: rdata_q <= rdata_i (loads only; stores leave it unchanged) -> DONE.
- DONE: mem_valid_o = 1 for exactly one cycle, misaligned_o = flag -> IDLE.
- mem_ready_o = 1 only in IDLE; a new micro-op is never accepted in DONE.
- Byte enables: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111. Loads use the same be_o.
- wdata_o: byte op3[7:0] replicated to 4 lanes; half op3[15:0] replicated twice; word op3.
- rdata_o = rdata_q, unshifted. Writeback selects the lane and extends the sign using mem_ctrl and exe_out[1:0].
- rvalid_i outside RESP is ignored. gnt_i outside REQ is ignored.
- mem2wb_o holds its last value while mem_valid_o = 0. Writeback samples it only on mem_valid_o.

## Timing
- Reset (rst_i high at an edge): state = IDLE, payload = 0, rdata_q = 0, flag = 0. Outputs after reset: mem_ready_o=1, mem_valid_o=0, misaligned_o=0, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, rdata_o=0, mem2wb_o=0.
- Reset mid-transaction: the FSM returns to IDLE immediately and req_o drops. A late rvalid_i is discarded and no mem_valid_o is produced.
- Pass-through / misaligned latency: accept at edge N, mem_valid_o high in cycle N+1.
- Memory op latency: accept at edge N, req_o high from cycle N+1. With grant in cycle G and response in cycle R (R > G), mem_valid_o is high in cycle R+1. Zero-wait case (G = N+1, R = N+2): mem_valid_o in cycle N+3.
- Throughput: at most one micro-op per 2 cycles (pass-through), per 4 cycles (zero-wait memory op).
- rdata_o is stable from cycle R+1 through at least R+2, which covers Writeback's read in the cycle after mem_valid_o.

## Test plan
- Reset, then hold exe_valid_i=0 for 10 cycles -> req_o=0, mem_valid_o=0, mem_ready_o=1 throughout.
- ALU op, exe_out=0x1234, rd=5 -> mem_valid_o one cycle after acceptance, mem2wb_o.exe_out=0x1234, mem2wb_o.rd=5, req_o never asserted.
- LW addr 0x100, gnt_i delayed 3 cycles, rvalid_i 2 cycles after grant with rdata_i=0xDEADBEEF -> addr_o=0x100, be_o=4'b1111, we_o=0, req_o held until grant, mem_valid_o the cycle after rvalid_i, rdata_o=0xDEADBEEF on the next cycle.
- SB addr 0x203, op3=0xAB -> addr_o=0x200, be_o=4'b1000, wdata_o=0xABABABAB, we_o=1; mem_valid_o only after rvalid_i; rdata_o unchanged.
- LH addr 0x101 -> no req_o, mem_valid_o and misaligned_o next cycle, mem2wb_o.rd=0, gpr_ctrl=GPR_IDLE.
- rst_i pulsed during RESP of an LW, then rvalid_i arrives -> no mem_valid_o, state IDLE, mem_ready_o=1, rdata_o=0.

Source files
------------

// File: rtl/memory_stage.sv
// MEM stage of the SCHOLAR RISC-V core: issues one OBI load/store at a time
// and hands the registered MEM->WB payload plus raw load data to Writeback.
package memory_stage_pkg;
  localparam logic [3:0] MEM_IDLE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [2:0] GPR_IDLE = 3'd0;
  localparam logic [2:0] CSR_IDLE = 3'd0;

  typedef struct packed {
    logic [31:0] exe_out;
    logic [31:0] op3;
    logic [4:0]  rd;
    logic [11:0] csr_waddr;
    logic [2:0]  gpr_ctrl;
    logic [2:0]  csr_ctrl;
    logic [3:0]  mem_ctrl;
  } exe2mem_t;

  typedef struct packed {
    logic [31:0] exe_out;
    logic [31:0] op3;
    logic [4:0]  rd;
    logic [11:0] csr_waddr;
    logic [2:0]  gpr_ctrl;
    logic [2:0]  csr_ctrl;
    logic [3:0]  mem_ctrl;
  } mem2wb_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    exe_valid_i,
  input  exe2mem_t                exe2mem_i,
  output logic                    mem_ready_o,
  output logic                    mem_valid_o,
  output mem2wb_t                 mem2wb_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    misaligned_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic                    rvalid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_reg;
  exe2mem_t              payload_reg;
  mem2wb_t               mem2wb_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  misaligned_reg;

  function automatic logic is_load(input logic [3:0] c);
    return (c == MEM_LB) || (c == MEM_LH) || (c == MEM_LW) ||
           (c == MEM_LBU) || (c == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] c);
    return (c == MEM_SB) || (c == MEM_SH) || (c == MEM_SW);
  endfunction

  function automatic mem2wb_t to_wb(input exe2mem_t p);
    mem2wb_t w;
    w.exe_out   = p.exe_out;
    w.op3       = p.op3;
    w.rd        = p.rd;
    w.csr_waddr = p.csr_waddr;
    w.gpr_ctrl  = p.gpr_ctrl;
    w.csr_ctrl  = p.csr_ctrl;
    w.mem_ctrl  = p.mem_ctrl;
    return w;
  endfunction

  // Misaligned accesses never reach the bus and must not write any register.
  logic     in_misaligned;
  exe2mem_t in_forced;

  always_comb begin
    in_misaligned = 1'b0;
    case (exe2mem_i.mem_ctrl)
      MEM_LH, MEM_LHU, MEM_SH: in_misaligned = exe2mem_i.exe_out[0];
      MEM_LW, MEM_SW:          in_misaligned = (exe2mem_i.exe_out[1:0] != 2'b00);
      default:                 in_misaligned = 1'b0;
    endcase
    in_forced          = exe2mem_i;
    in_forced.gpr_ctrl = GPR_IDLE;
    in_forced.csr_ctrl = CSR_IDLE;
    in_forced.rd       = 5'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      payload_reg    <= '0;
      mem2wb_reg     <= '0;
      rdata_reg      <= '0;
      misaligned_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (exe_valid_i) begin
            misaligned_reg <= 1'b0;
            if (exe2mem_i.mem_ctrl == MEM_IDLE) begin
              payload_reg <= exe2mem_i;
              mem2wb_reg  <= to_wb(exe2mem_i);
              state_reg   <= DONE;
            end else if (in_misaligned) begin
              payload_reg    <= in_forced;
              mem2wb_reg     <= to_wb(in_forced);
              misaligned_reg <= 1'b1;
              state_reg      <= DONE;
            end else begin
              payload_reg <= exe2mem_i;
              state_reg   <= REQ;
            end
          end
        end
        REQ: begin
          if (gnt_i) state_reg <= RESP;
        end
        RESP: begin
          if (rvalid_i) begin
            if (is_load(payload_reg.mem_ctrl)) rdata_reg <= rdata_i;
            mem2wb_reg <= to_wb(payload_reg);
            state_reg  <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Bus-side signals are derived from the captured payload so they stay
  // stable for the whole address phase.
  logic [1:0] offset;
  assign offset = payload_reg.exe_out[1:0];

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    case (payload_reg.mem_ctrl)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be_o    = {{(DATA_WIDTH/8-1){1'b0}}, 1'b1} << offset;
        wdata_o = {(DATA_WIDTH/8){payload_reg.op3[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be_o    = {{(DATA_WIDTH/8-2){1'b0}}, 2'b11} << offset;
        wdata_o = {(DATA_WIDTH/16){payload_reg.op3[15:0]}};
      end
      MEM_LW, MEM_SW: begin
        be_o    = '1;
        wdata_o = payload_reg.op3[DATA_WIDTH-1:0];
      end
      default: begin
        be_o    = '0;
        wdata_o = '0;
      end
    endcase
  end

  assign addr_o       = {payload_reg.exe_out[ADDR_WIDTH-1:2], 2'b00};
  assign we_o         = is_store(payload_reg.mem_ctrl);
  assign req_o        = (state_reg == REQ);
  assign mem_ready_o  = (state_reg == IDLE);
  assign mem_valid_o  = (state_reg == DONE);
  assign misaligned_o = (state_reg == DONE) && misaligned_reg;
  assign mem2wb_o     = mem2wb_reg;
  assign rdata_o      = rdata_reg;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads/stores with OBI
// wait states, misaligned access and reset during an outstanding response.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid;
  exe2mem_t    exe2mem;
  logic        mem_ready, mem_valid, misaligned;
  mem2wb_t     mem2wb;
  logic [31:0] rdata;
  logic        req, gnt, we, rvalid;
  logic [31:0] addr, wdata, rdata_bus;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .exe_valid_i(exe_valid), .exe2mem_i(exe2mem),
    .mem_ready_o(mem_ready), .mem_valid_o(mem_valid), .mem2wb_o(mem2wb),
    .rdata_o(rdata), .misaligned_o(misaligned),
    .req_o(req), .gnt_i(gnt), .addr_o(addr), .we_o(we), .be_o(be),
    .wdata_o(wdata), .rvalid_i(rvalid), .rdata_i(rdata_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [31:0] eo,
                       input logic [31:0] op3, input logic [4:0] rd,
                       input logic [2:0] gpr);
    exe2mem           = '0;
    exe2mem.mem_ctrl  = ctrl;
    exe2mem.exe_out   = eo;
    exe2mem.op3       = op3;
    exe2mem.rd        = rd;
    exe2mem.gpr_ctrl  = gpr;
    exe2mem.csr_ctrl  = 3'd2;
    exe2mem.csr_waddr = 12'h305;
    exe_valid         = 1'b1;
    check("accept_ready", {31'd0, mem_ready}, 32'd1);
    step();
    exe_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; exe_valid = 1'b0; exe2mem = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata_bus = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mis",   {31'd0, misaligned}, 32'd0);
    check("rst_req",   {31'd0, req}, 32'd0);
    check("rst_we",    {31'd0, we}, 32'd0);
    check("rst_be",    {28'd0, be}, 32'd0);
    check("rst_addr",  addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_wb_exe", mem2wb.exe_out, 32'd0);

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_req_valid_ready", {29'd0, req, mem_valid, mem_ready}, 32'd1);
    end

    // ALU pass-through
    issue(MEM_IDLE, 32'h1234, 32'h0, 5'd5, 3'd1);
    check("alu_valid", {31'd0, mem_valid}, 32'd1);
    check("alu_req",   {31'd0, req}, 32'd0);
    check("alu_ready", {31'd0, mem_ready}, 32'd0);
    check("alu_exe",   mem2wb.exe_out, 32'h1234);
    check("alu_rd",    {27'd0, mem2wb.rd}, 32'd5);
    check("alu_mis",   {31'd0, misaligned}, 32'd0);
    step();
    check("alu_pulse_end", {31'd0, mem_valid}, 32'd0);

    // LW 0x100, grant delayed 3 cycles, response 2 cycles after grant
    issue(MEM_LW, 32'h100, 32'h0, 5'd9, 3'd1);
    for (int i = 0; i < 3; i++) begin
      check("lw_req_hold", {31'd0, req}, 32'd1);
      check("lw_addr", addr, 32'h100);
      check("lw_be", {28'd0, be}, 32'hF);
      check("lw_we", {31'd0, we}, 32'd0);
      step();
    end
    gnt = 1'b1;
    check("lw_req_at_gnt", {31'd0, req}, 32'd1);
    step();
    gnt = 1'b0;
    check("lw_req_drop", {31'd0, req}, 32'd0);
    check("lw_wait_valid", {31'd0, mem_valid}, 32'd0);
    step();
    rvalid = 1'b1; rdata_bus = 32'hDEADBEEF;
    check("lw_rvalid_cycle_valid", {31'd0, mem_valid}, 32'd0);
    step();
    rvalid = 1'b0; rdata_bus = 32'h0;
    check("lw_valid", {31'd0, mem_valid}, 32'd1);
    check("lw_wb_rd", {27'd0, mem2wb.rd}, 32'd9);
    step();
    check("lw_rdata_next", rdata, 32'hDEADBEEF);
    check("lw_pulse_end", {31'd0, mem_valid}, 32'd0);

    // SB 0x203, zero wait states
    issue(MEM_SB, 32'h203, 32'hAB, 5'd0, 3'd0);
    check("sb_addr", addr, 32'h200);
    check("sb_be", {28'd0, be}, 32'h8);
    check("sb_wdata", wdata, 32'hABABABAB);
    check("sb_we", {31'd0, we}, 32'd1);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check("sb_resp_valid", {31'd0, mem_valid}, 32'd0);
    rvalid = 1'b1; rdata_bus = 32'h11111111;
    step();
    rvalid = 1'b0;
    check("sb_valid", {31'd0, mem_valid}, 32'd1);
    check("sb_rdata_kept", rdata, 32'hDEADBEEF);
    step();

    // SH 0x202, upper half lanes
    issue(MEM_SH, 32'h202, 32'h1234CDEF, 5'd0, 3'd0);
    check("sh_be", {28'd0, be}, 32'hC);
    check("sh_wdata", wdata, 32'hCDEFCDEF);
    check("sh_addr", addr, 32'h200);
    gnt = 1'b1; step(); gnt = 1'b0;
    rvalid = 1'b1; step(); rvalid = 1'b0;
    check("sh_valid", {31'd0, mem_valid}, 32'd1);
    step();

    // LH 0x101: misaligned, no bus access
    issue(MEM_LH, 32'h101, 32'h0, 5'd7, 3'd1);
    check("lh_req", {31'd0, req}, 32'd0);
    check("lh_valid", {31'd0, mem_valid}, 32'd1);
    check("lh_mis", {31'd0, misaligned}, 32'd1);
    check("lh_rd", {27'd0, mem2wb.rd}, 32'd0);
    check("lh_gpr", {29'd0, mem2wb.gpr_ctrl}, {29'd0, GPR_IDLE});
    check("lh_csr", {29'd0, mem2wb.csr_ctrl}, {29'd0, CSR_IDLE});
    step();
    check("lh_mis_end", {31'd0, misaligned}, 32'd0);

    // Reset during RESP of an LW, then a late response
    issue(MEM_LW, 32'h104, 32'h0, 5'd3, 3'd1);
    gnt = 1'b1; step(); gnt = 1'b0;
    check("rr_in_resp_req", {31'd0, req}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_ready", {31'd0, mem_ready}, 32'd1);
    rvalid = 1'b1; rdata_bus = 32'hCAFEF00D;
    step();
    rvalid = 1'b0;
    check("rr_no_valid", {31'd0, mem_valid}, 32'd0);
    check("rr_ready2", {31'd0, mem_ready}, 32'd1);
    check("rr_rdata", rdata, 32'd0);
    check("rr_req", {31'd0, req}, 32'd0);
    step();
    check("rr_no_valid_late", {31'd0, mem_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
